// File: rtl/aem_pkg.sv
// Shared types and helpers for the approximate-adder error monitor.
package aem_pkg;

    localparam int AEM_N = 16;
    localparam int ED_W  = AEM_N + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } aem_state_e;

    // Operands are pre-extended to 64 bits; accumulators stay well below that width.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input logic signed [63:0] lo,
                                                   input logic signed [63:0] hi);
        logic signed [63:0] s;
        s = a + b;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic logic sat_ovf(input logic signed [63:0] a,
                                     input logic signed [63:0] b,
                                     input logic signed [63:0] lo,
                                     input logic signed [63:0] hi);
        logic signed [63:0] s;
        s = a + b;
        return (s > hi) || (s < lo);
    endfunction

endpackage

// File: rtl/aem_ed_calc.sv
// Exact sum and error distance for one sample; AEM_BIAS_EN adds the signed difference.
module aem_ed_calc #(
    parameter int N = 16
) (
    input  logic [N-1:0]      op_a,
    input  logic [N-1:0]      op_b,
    input  logic [N-1:0]      approx_sum,
    input  logic              approx_co,
`ifdef AEM_BIAS_EN
    output logic signed [N+1:0] diff,
`endif
    output logic [N:0]        ed
);

    logic [N:0] exact;
    logic [N:0] approx;

    assign exact  = {1'b0, op_a} + {1'b0, op_b};
    assign approx = {approx_co, approx_sum};
    assign ed     = (exact >= approx) ? (exact - approx) : (approx - exact);

`ifdef AEM_BIAS_EN
    assign diff = $signed({1'b0, approx}) - $signed({1'b0, exact});
`endif

endmodule

// File: rtl/approx_error_monitor.sv
// Windowed error statistics for an approximate adder; AEM_BIAS_EN adds a signed
// bias accumulator output (err_bias).
module approx_error_monitor
    import aem_pkg::*;
#(
    parameter int N      = AEM_N,
    parameter int WINDOW = 1024,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     op_a,
    input  logic [N-1:0]     op_b,
    input  logic [N-1:0]     approx_sum,
    input  logic             approx_co,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [N:0]       ed_max,
`ifdef AEM_BIAS_EN
    output logic signed [ACC_W:0] err_bias,
`endif
    output logic             sat
);

    localparam int EW = N + 1;
    localparam logic signed [63:0] ACC_MAX = (64'sd1 <<< ACC_W) - 64'sd1;

    aem_state_e       state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [2:1]       vld_pipe_q;
    logic             fire, zero_stats;

    logic [EW-1:0]    ed_c, ed_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, err_q, err_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [EW-1:0]    max_q, max_d;
    logic             sat_q, sat_d;

`ifdef AEM_BIAS_EN
    localparam logic signed [63:0] BIAS_MAX = (64'sd1 <<< ACC_W) - 64'sd1;
    localparam logic signed [63:0] BIAS_MIN = -(64'sd1 <<< ACC_W);
    logic signed [EW:0]    diff_c, diff_q;
    logic signed [ACC_W:0] bias_q, bias_d;
`endif

    assign in_ready = (state_q == ST_RUN) && (acc_q < CNT_W'(WINDOW));
    assign fire     = in_valid && in_ready;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);

    aem_ed_calc #(.N(N)) u_ed_calc (
        .op_a       (op_a),
        .op_b       (op_b),
        .approx_sum (approx_sum),
        .approx_co  (approx_co),
`ifdef AEM_BIAS_EN
        .diff       (diff_c),
`endif
        .ed         (ed_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // clear overrides every state transition, including a simultaneous start.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        zero_stats = 1'b0;
        if (clear) begin
            state_d    = ST_IDLE;
            acc_d      = '0;
            zero_stats = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) begin
                    state_d    = ST_RUN;
                    acc_d      = '0;
                    zero_stats = 1'b1;
                end
                ST_RUN: if (fire) begin
                    acc_d = acc_q + CNT_W'(1);
                    if (acc_q == CNT_W'(WINDOW - 1)) state_d = ST_DRAIN;
                end
                ST_DRAIN: if (vld_pipe_q == '0) state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        sum_d = sum_q;
        max_d = max_q;
        sat_d = sat_q;
`ifdef AEM_BIAS_EN
        bias_d = bias_q;
`endif
        if (zero_stats) begin
            cnt_d = '0;
            err_d = '0;
            sum_d = '0;
            max_d = '0;
            sat_d = 1'b0;
`ifdef AEM_BIAS_EN
            bias_d = '0;
`endif
        end else if (vld_pipe_q[1]) begin
            cnt_d = cnt_q + CNT_W'(1);
            err_d = err_q + CNT_W'(ed_q != '0);
            sum_d = ACC_W'(sat_add(64'(sum_q), 64'(ed_q), 64'sd0, ACC_MAX));
            sat_d = sat_q | sat_ovf(64'(sum_q), 64'(ed_q), 64'sd0, ACC_MAX);
            max_d = (ed_q > max_q) ? ed_q : max_q;
`ifdef AEM_BIAS_EN
            bias_d = (ACC_W+1)'(sat_add(64'(bias_q), 64'(diff_q), BIAS_MIN, BIAS_MAX));
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            ed_q       <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            sum_q      <= '0;
            max_q      <= '0;
            sat_q      <= 1'b0;
`ifdef AEM_BIAS_EN
            diff_q     <= '0;
            bias_q     <= '0;
`endif
        end else begin
            vld_pipe_q <= clear ? 2'b00 : {vld_pipe_q[1], fire};
            if (fire) ed_q <= ed_c;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            sum_q      <= sum_d;
            max_q      <= max_d;
            sat_q      <= sat_d;
`ifdef AEM_BIAS_EN
            if (fire) diff_q <= diff_c;
            bias_q     <= bias_d;
`endif
        end
    end

    assign sample_cnt = cnt_q;
    assign err_cnt    = err_q;
    assign ed_sum     = sum_q;
    assign ed_max     = max_q;
    assign sat        = sat_q;
`ifdef AEM_BIAS_EN
    assign err_bias   = bias_q;
`endif

endmodule
